// File: rtl/alu_pkg.sv
// Shared constants and encodings for the 16-bit bitwise logic datapath.
// Used by the register file and the operand stage that feeds the logic units.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } logic_op_e;

  // The operand pipeline register is either empty or holds one operand set.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } opnd_state_e;

endpackage

// File: rtl/regfile_8x16.sv
// 8x16 general register file: R0 hardwired to zero, one write port and two
// combinational read ports that forward a same-cycle write.
import alu_pkg::*;

module regfile_8x16 (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_live;

  // Writes to R0 are dropped so regs[0] stays at its reset value of zero.
  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass lets a reader see the value being written this same cycle.
  assign rd_data_a = (rd_addr_a == '0)                  ? '0      :
                     (wr_live && (wr_addr == rd_addr_a)) ? wr_data :
                                                           regs[rd_addr_a];

  assign rd_data_b = (rd_addr_b == '0)                  ? '0      :
                     (wr_live && (wr_addr == rd_addr_b)) ? wr_data :
                                                           regs[rd_addr_b];

endmodule

// File: rtl/regfile_operand_stage.sv
// Operand stage for the logic units: reads two sources from the register
// file and holds operand pair plus opcode in an output pipeline register.
import alu_pkg::*;

module regfile_operand_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic [OP_W-1:0]   issue_op,
  output logic              opnd_valid,
  input  logic              opnd_ready,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  output logic [OP_W-1:0]   opnd_op
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high. A valid producer holds its payload stable until that edge;
  // ready may depend combinationally on the consumer's ready, never on valid.
  opnd_state_e       state;
  opnd_state_e       state_next;
  logic              accept;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  regfile_8x16 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rs_a),
    .rd_addr_b (rs_b),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b)
  );

  assign opnd_valid  = (state == ST_FULL);
  assign issue_ready = (state == ST_EMPTY) || opnd_ready;
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (opnd_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Captured operands are a snapshot; later writes do not refresh them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      opnd_a  <= '0;
      opnd_b  <= '0;
      opnd_op <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        opnd_a  <= rd_a;
        opnd_b  <= rd_b;
        opnd_op <= issue_op;
      end
    end
  end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: a register/queue model
// checked every cycle, plus directed steps with hand-computed literals.
import alu_pkg::*;

module tb_regfile_operand_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] rs_a;
  logic [ADDR_W-1:0] rs_b;
  logic [OP_W-1:0]   issue_op;
  logic              opnd_valid;
  logic              opnd_ready;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [OP_W-1:0]   opnd_op;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regfile_operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .issue_op    (issue_op),
    .opnd_valid  (opnd_valid),
    .opnd_ready  (opnd_ready),
    .opnd_a      (opnd_a),
    .opnd_b      (opnd_b),
    .opnd_op     (opnd_op)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // Register contents as the architecture defines them, and a queue of
  // operand sets the logic units are still owed (at most one outstanding).
  logic [DATA_W-1:0]               m_regs [NREGS];
  logic [OP_W+2*DATA_W-1:0]        exp_q[$];
  bit                              armed = 0;
  bit                              m_rdy;

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1;
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      exp_q.delete();
    end else if (armed) begin
      m_rdy = (exp_q.size() == 0) || opnd_ready;
      if (exp_q.size() != 0 && opnd_ready) void'(exp_q.pop_front());
      if (issue_valid && m_rdy) exp_q.push_back({issue_op, m_read(rs_a), m_read(rs_b)});
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
    end
  end

  // Outputs are compared every cycle, mid-way between rising edges.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_valid", {31'd0, opnd_valid}, {31'd0, exp_q.size() != 0});
      chk("model_issue_ready", {31'd0, issue_ready},
          {31'd0, (exp_q.size() == 0) || opnd_ready});
      if (exp_q.size() != 0) begin
        chk("model_op", {30'd0, opnd_op}, {30'd0, exp_q[0][2*DATA_W +: OP_W]});
        chk("model_a", {16'd0, opnd_a}, {16'd0, exp_q[0][DATA_W +: DATA_W]});
        chk("model_b", {16'd0, opnd_b}, {16'd0, exp_q[0][0 +: DATA_W]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic iss(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                     input logic [OP_W-1:0] op);
    issue_valid = 1'b1; rs_a = a; rs_b = b; issue_op = op;
  endtask

  int stream_cnt;

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; rs_a = '0; rs_b = '0; issue_op = '0; opnd_ready = 1'b1;

    // 1: reset for two edges, then issue from never-written registers
    cycle(); cycle();
    rst = 1'b0;
    mid();
    chk("rst_valid", {31'd0, opnd_valid}, 32'd0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    cycle();
    iss(3, 5, OP_XOR);
    cycle();
    issue_valid = 1'b0;
    mid();
    chk("rst_read_valid", {31'd0, opnd_valid}, 32'd1);
    chk("rst_read_a", {16'd0, opnd_a}, 32'h0000);
    chk("rst_read_b", {16'd0, opnd_b}, 32'h0000);

    // 2: write then read
    cycle(); wr(3, 16'hA5A5);
    cycle(); wr(5, 16'h0FF0);
    cycle(); wr_en = 1'b0; iss(3, 5, OP_AND);
    cycle(); issue_valid = 1'b0;
    mid();
    chk("wr_rd_a", {16'd0, opnd_a}, 32'hA5A5);
    chk("wr_rd_b", {16'd0, opnd_b}, 32'h0FF0);
    chk("wr_rd_op", {30'd0, opnd_op}, 32'd0);

    // 3: same-cycle write bypass on both ports
    cycle(); wr(2, 16'h1234); iss(2, 2, OP_OR);
    cycle(); wr_en = 1'b0; issue_valid = 1'b0;
    mid();
    chk("bypass_a", {16'd0, opnd_a}, 32'h1234);
    chk("bypass_b", {16'd0, opnd_b}, 32'h1234);
    chk("bypass_op", {30'd0, opnd_op}, 32'd1);

    // 4: R0 ignores writes
    cycle(); wr(0, 16'hFFFF);
    cycle(); wr_en = 1'b0; iss(0, 3, OP_NOT);
    cycle(); issue_valid = 1'b0;
    mid();
    chk("r0_a", {16'd0, opnd_a}, 32'h0000);
    chk("r0_b", {16'd0, opnd_b}, 32'hA5A5);
    chk("r0_op", {30'd0, opnd_op}, 32'd3);

    // 5: backpressure holds a snapshot while the source is overwritten
    cycle(); opnd_ready = 1'b0; iss(5, 3, OP_XOR);
    cycle(); issue_valid = 1'b0; wr(5, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("stall_valid", {31'd0, opnd_valid}, 32'd1);
      chk("stall_a", {16'd0, opnd_a}, 32'h0FF0);
      chk("stall_b", {16'd0, opnd_b}, 32'hA5A5);
      chk("stall_issue_ready", {31'd0, issue_ready}, 32'd0);
      cycle();
      wr_en = 1'b0;
    end
    opnd_ready = 1'b1; iss(5, 0, OP_AND);
    mid();
    chk("release_issue_ready", {31'd0, issue_ready}, 32'd1);
    cycle(); issue_valid = 1'b0;
    mid();
    chk("release_a", {16'd0, opnd_a}, 32'hBEEF);
    chk("release_b", {16'd0, opnd_b}, 32'h0000);

    // 6: fill R1..R7, stream eight back-to-back issues, then reset while FULL
    cycle();
    for (int r = 1; r < NREGS; r++) begin
      wr(r[ADDR_W-1:0], 16'h1111 * r[15:0]);
      cycle();
    end
    wr_en = 1'b0;
    stream_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      iss(ADDR_W'((i % 7) + 1), ADDR_W'(7 - (i % 7)), OP_W'(i));
      cycle();
      mid();
      if (opnd_valid === 1'b1) stream_cnt++;
    end
    issue_valid = 1'b0;
    chk("stream_no_bubble", stream_cnt, 32'd8);
    chk("stream_last_a", {16'd0, opnd_a}, 32'h1111);
    chk("stream_last_b", {16'd0, opnd_b}, 32'h7777);
    cycle();
    opnd_ready = 1'b0; iss(7, 1, OP_OR);
    cycle(); issue_valid = 1'b0;
    mid();
    chk("pre_rst_valid", {31'd0, opnd_valid}, 32'd1);
    rst = 1'b1;
    cycle(); rst = 1'b0;
    mid();
    chk("mid_rst_valid", {31'd0, opnd_valid}, 32'd0);
    chk("mid_rst_a", {16'd0, opnd_a}, 32'h0000);
    opnd_ready = 1'b1;
    for (int r = 1; r < NREGS; r++) begin
      iss(r[ADDR_W-1:0], r[ADDR_W-1:0], OP_AND);
      cycle();
      mid();
      chk("post_rst_reg_a", {16'd0, opnd_a}, 32'h0000);
      chk("post_rst_reg_b", {16'd0, opnd_b}, 32'h0000);
    end
    issue_valid = 1'b0;
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
